ram_access_ctrl: RTL and testbench

- Front-end controller that drives the 32x4 RAM from board inputs on the DE1-SoC.
- Write path: synchronizes and edge-detects the raw active-low write key. Issues exactly one write strobe per press, with the address and data registered at that press.
- Read path: auto-scans the RAM read address at a fixed tick rate and registers the returned read data for the HEX display stage.
- Sits between the switch/KEY inputs and the RAM's write and read ports.

---
 rtl/ram_access_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ram_access_ctrl: key-driven single-strobe RAM writer plus timed read    |
// | address scanner with registered read data for display.                  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module ram_access_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 4,
   parameter int SCAN_DIV = 50000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              key_n,
   input  logic              sw_wr_en,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              scan_pause,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data_q,
   output logic              scan_tick
);

   localparam int                c_div_w   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_capture;
   logic                r_key_meta;
   logic                r_key_s;
   logic                r_key_prev;
   logic [1:0]          r_prime;
   logic                r_armed;
   logic                w_press;
   logic [c_div_w-1:0]  r_div;

   // Two-flop synchronizer; r_prime marks when key_s reflects the real key
   // after reset so a key held through reset cannot fake a press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_key_meta <= 1'b1;
         r_key_s    <= 1'b1;
         r_key_prev <= 1'b1;
         r_prime    <= 2'b00;
         r_armed    <= 1'b0;
      end else begin
         r_key_meta <= key_n;
         r_key_s    <= r_key_meta;
         r_key_prev <= r_key_s;
         r_prime    <= {r_prime[0], 1'b1};
         r_armed    <= r_armed | (r_prime[1] & r_key_s);
      end
   end

   assign w_press = r_armed & r_key_prev & ~r_key_s;

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press) begin
               w_capture    = sw_wr_en;
               w_next_state = sw_wr_en ? WRITE : HOLD;
            end
         end
         WRITE:   w_next_state = HOLD;
         HOLD:    if (r_key_s) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         r_state <= w_next_state;
         wr_en   <= (w_next_state == WRITE);
         if (w_capture) begin
            wr_addr <= sw_addr;
            wr_data <= sw_data;
         end
      end
   end

   // Read scanner: pause freezes the divider mid-count so resume is seamless.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_div     <= '0;
         rd_addr   <= '0;
         scan_tick <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data;
         scan_tick <= 1'b0;
         if (!scan_pause) begin
            if (r_div == c_div_max) begin
               r_div     <= '0;
               rd_addr   <= rd_addr + ADDR_W'(1);
               scan_tick <= 1'b1;
            end else begin
               r_div <= r_div + c_div_w'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ram_access_ctrl: directed vector bench with a small RAM model.       |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_ram_access_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       key_n;
   logic       sw_wr_en;
   logic [4:0] sw_addr;
   logic [3:0] sw_data;
   logic       scan_pause;
   logic [3:0] rd_data = '0;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [3:0] wr_data;
   logic [4:0] rd_addr;
   logic [3:0] rd_data_q;
   logic       scan_tick;

   logic [3:0] mem [32] = '{default: 4'h0};

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;
   int first_edge;
   int edge_cnt;

   typedef struct {
      logic       en;
      logic [4:0] addr;
      logic [3:0] data;
      int         hold;
      int         exp_pulses;
      int         exp_first;
      logic [4:0] exp_addr;
      logic [3:0] exp_data;
   } wvec_t;

   wvec_t vecs [4];

   ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .key_n      (key_n),
      .sw_wr_en   (sw_wr_en),
      .sw_addr    (sw_addr),
      .sw_data    (sw_data),
      .scan_pause (scan_pause),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data_q  (rd_data_q),
      .scan_tick  (scan_tick)
   );

   always #5 clock = ~clock;

   // Write-first registered RAM model
   always @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         edge_cnt++;
         if (wr_en) begin
            pulses++;
            if (first_edge < 0) first_edge = edge_cnt;
         end
      end
   endtask

   task automatic do_press(input logic en, input logic [4:0] addr,
                           input logic [3:0] data, input int hold);
      sw_wr_en   = en;
      sw_addr    = addr;
      sw_data    = data;
      edge_cnt   = 0;
      pulses     = 0;
      first_edge = -1;
      key_n      = 1'b0;
      run_cycles(hold);
      key_n = 1'b1;
      run_cycles(6);
   endtask

   task automatic wait_tick_at(input logic [4:0] addr, output bit found);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (scan_tick && rd_addr == addr) found = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      int bad_tick;

      vecs[0] = '{1'b1, 5'd2,  4'hA, 10, 1,  3, 5'd2,  4'hA};
      vecs[1] = '{1'b0, 5'd9,  4'h3, 10, 0, -1, 5'd2,  4'hA};
      vecs[2] = '{1'b1, 5'd31, 4'hF, 4,  1,  3, 5'd31, 4'hF};
      vecs[3] = '{1'b1, 5'd0,  4'h0, 3,  1,  3, 5'd0,  4'h0};

      reset = 1'b1; key_n = 1'b1; sw_wr_en = 1'b0; sw_addr = '0;
      sw_data = '0; scan_pause = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_wr_en",     wr_en,     0);
      check("rst_wr_addr",   wr_addr,   0);
      check("rst_wr_data",   wr_data,   0);
      check("rst_rd_addr",   rd_addr,   0);
      check("rst_rd_data_q", rd_data_q, 0);
      check("rst_scan_tick", scan_tick, 0);
      reset = 1'b0;

      // Scanner: advance every 4 cycles, wrap 31 -> 0 after 32 steps
      bad_tick = 0;
      for (int step = 1; step <= 33; step++) begin
         for (int c = 1; c <= 4; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c < 4 && scan_tick) bad_tick++;
            if (c < 4 && wr_en) bad_tick++;
         end
         check("scan_rd_addr", rd_addr, step % 32);
         check("scan_tick_on_step", scan_tick, 1);
      end
      check("scan_tick_between_steps", bad_tick, 0);

      // Key press vectors
      for (int v = 0; v < 4; v++) begin
         do_press(vecs[v].en, vecs[v].addr, vecs[v].data, vecs[v].hold);
         check("press_pulse_count", pulses,     vecs[v].exp_pulses);
         check("press_latency",     first_edge, vecs[v].exp_first);
         check("press_wr_addr",     wr_addr,    vecs[v].exp_addr);
         check("press_wr_data",     wr_data,    vecs[v].exp_data);
      end

      // Pause with divider at 2 and rd_addr at 7
      wait_tick_at(5'd7, found);
      check("pause_reach_addr7", found, 1);
      repeat (2) begin @(posedge clock); @(negedge clock); end
      scan_pause = 1'b1;
      bad_tick = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (rd_addr != 5'd7 || scan_tick) bad_tick++;
      end
      check("pause_hold", bad_tick, 0);
      scan_pause = 1'b0;
      @(posedge clock); @(negedge clock);
      check("resume_edge1_addr", rd_addr, 7);
      @(posedge clock); @(negedge clock);
      check("resume_edge2_addr", rd_addr, 8);
      check("resume_edge2_tick", scan_tick, 1);

      // Collision: write to the paused read address
      wait_tick_at(5'd3, found);
      check("coll_reach_addr3", found, 1);
      scan_pause = 1'b1;
      repeat (3) begin @(posedge clock); @(negedge clock); end
      check("coll_before", rd_data_q, 0);
      sw_wr_en = 1'b1; sw_addr = 5'd3; sw_data = 4'h5;
      key_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(posedge clock); @(negedge clock);
         if (wr_en) found = 1'b1;
      end
      check("coll_wr_en_seen", found, 1);
      repeat (2) begin @(posedge clock); @(negedge clock); end
      check("coll_rd_data_q", rd_data_q, 5);
      check("coll_rd_addr", rd_addr, 3);
      key_n = 1'b1;
      repeat (6) begin @(posedge clock); @(negedge clock); end
      scan_pause = 1'b0;

      // Reset during WRITE with key held
      sw_wr_en = 1'b1; sw_addr = 5'd4; sw_data = 4'h6;
      key_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(posedge clock); @(negedge clock);
         if (wr_en) found = 1'b1;
      end
      check("rst6_wr_en_seen", found, 1);
      reset = 1'b1;
      #1;
      check("rst6_wr_en_drop", wr_en, 0);
      check("rst6_wr_addr", wr_addr, 0);
      @(negedge clock);
      reset = 1'b0;
      edge_cnt = 0; pulses = 0; first_edge = -1;
      run_cycles(10);
      check("rst6_held_no_pulse", pulses, 0);
      key_n = 1'b1;
      run_cycles(6);
      check("rst6_release_no_pulse", pulses, 0);
      do_press(1'b1, 5'd4, 4'h6, 5);
      check("rst6_repress_pulses",  pulses,     1);
      check("rst6_repress_latency", first_edge, 3);
      check("rst6_repress_wr_addr", wr_addr,    4);
      check("rst6_repress_wr_data", wr_data,    6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
